// File: rtl/hex_page_selector.sv
// Pages a captured 32-bit word onto a 6-digit nibble bus (HI = upper 24 bits, LO = low byte).
// A debounced active-low key toggles the view; HEX_PAGE_SELECTOR_AUTO_SCROLL_EN adds timed paging.
module hex_page_selector #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned SCROLL_TICKS    = 50000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] data_in,
    input  logic        load,
    input  logic        key_n,
    output logic [23:0] d_out,
    output logic        page,
    output logic        valid
);

    localparam logic [0:0] S_HI = 1'b0;
    localparam logic [0:0] S_LO = 1'b1;

    localparam int unsigned       DB_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [DB_W-1:0]   DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    logic            key_s1_q;
    logic            key_s2_q;
    logic            key_acc_q;
    logic            key_acc_d;
    logic [DB_W-1:0] db_cnt_q;
    logic [DB_W-1:0] db_cnt_d;
    logic            press_q;
    logic            press_d;
    logic [31:0]     word_q;
    logic            valid_q;
    logic [0:0]      state_q;
    logic [0:0]      state_d;
    logic [23:0]     d_out_q;
    logic [23:0]     d_out_d;
    logic            page_q;
    logic            scroll_tick;

    always_comb begin
        key_acc_d = key_acc_q;
        db_cnt_d  = '0;
        if (key_s2_q != key_acc_q) begin
            if (db_cnt_q == DB_LAST) begin
                key_acc_d = key_s2_q;
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end
        press_d = key_acc_q & ~key_acc_d;
    end

`ifdef HEX_PAGE_SELECTOR_AUTO_SCROLL_EN
    localparam int unsigned     SC_W    = $clog2(SCROLL_TICKS);
    localparam logic [SC_W-1:0] SC_LAST = SC_W'(SCROLL_TICKS - 1);

    logic [SC_W-1:0] scroll_cnt_q;
    logic [SC_W-1:0] scroll_cnt_d;

    assign scroll_tick = valid_q && (scroll_cnt_q == SC_LAST);

    // Any manual action restarts the full interval.
    always_comb begin
        scroll_cnt_d = scroll_cnt_q + 1'b1;
        if (load || press_q || !valid_q || scroll_tick) begin
            scroll_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scroll_cnt_q <= '0;
        end else begin
            scroll_cnt_q <= scroll_cnt_d;
        end
    end
`else
    logic unused_scroll;
    assign unused_scroll = (SCROLL_TICKS != 0);
    assign scroll_tick   = 1'b0;
`endif

    // Load outranks a same-cycle press, which is dropped.
    always_comb begin
        state_d = state_q;
        if (load) begin
            state_d = S_HI;
        end else if (press_q || scroll_tick) begin
            state_d = ~state_q;
        end
        d_out_d = (state_q == S_LO) ? {16'h0000, word_q[7:0]} : word_q[31:8];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_s1_q  <= 1'b1;
            key_s2_q  <= 1'b1;
            key_acc_q <= 1'b1;
            db_cnt_q  <= '0;
            press_q   <= 1'b0;
            word_q    <= '0;
            valid_q   <= 1'b0;
            state_q   <= S_HI;
            d_out_q   <= '0;
            page_q    <= 1'b0;
        end else begin
            key_s1_q  <= key_n;
            key_s2_q  <= key_s1_q;
            key_acc_q <= key_acc_d;
            db_cnt_q  <= db_cnt_d;
            press_q   <= press_d;
            state_q   <= state_d;
            d_out_q   <= d_out_d;
            page_q    <= state_q[0];
            if (load) begin
                word_q  <= data_in;
                valid_q <= 1'b1;
            end
        end
    end

    assign d_out = d_out_q;
    assign page  = page_q;
    assign valid = valid_q;

endmodule

// File: doc/hex_page_selector.md
Name: hex_page_selector

Overview:
- Upstream feeder for the 6-digit hex display decoder stage.
- Captures a 32-bit word and drives the 24-bit nibble bus that the six-display decoder consumes.
- Six digits cannot show eight nibbles, so the block pages between two views:
  - HI: upper 6 nibbles.
  - LO: lowest 2 nibbles, zero-padded.
- A debounced board key (active-low) toggles between the views.

Parameters:
- DEBOUNCE_CYCLES, 500000: consecutive cycles a synchronized key level must be stable before it is accepted (min 2).
- SCROLL_TICKS, 50000000: cycles between automatic page flips (used only with AUTO_SCROLL_EN; min 2).

Ports:
- clk  input  1  system clock, single domain.
- rst_n  input  1  asynchronous active-low reset.
- data_in  input  32  word to display.
- load  input  1  one-cycle strobe; captures data_in.
- key_n  input  1  raw pushbutton, active-low, asynchronous to clk.
- d_out  output  24  nibble bus to the display decoder; [23:20] drives the leftmost digit.
- page  output  1  0 = HI view, 1 = LO view.
- valid  output  1  high once at least one word has been loaded.

Behaviour:
- Reset (rst_n low, asynchronous assert; release synchronous to clk):
  - Internal: word_reg=0, state=S_HI, sync flops=1, accepted key level=1, debounce counter=0, scroll counter=0.
  - Outputs: d_out=24'h000000, page=0, valid=0.
- Capture: on a clk edge with load=1, word_reg<=data_in, state<=S_HI, valid<=1. A load during S_LO forces a return to S_HI.
- Key path:
  - Two-flop synchronizer on key_n.
  - Debounce counter counts while the synchronized level differs from the accepted level. It clears when they match.
  - When the count reaches DEBOUNCE_CYCLES-1, the accepted level takes the synchronized level and the counter clears.
  - A press event is a single-cycle pulse when the accepted level goes 1->0. Release generates no event.
- FSM states S_HI and S_LO:
  - S_HI -> S_LO on a press event.
  - S_LO -> S_HI on a press event or on load.
  - Otherwise the state holds.
- Priority in one cycle: load over press event (the press is dropped) over scroll tick.
- Output mapping, registered so d_out reflects state/word_reg one cycle after they change:
  - S_HI: d_out = word_reg[31:8].
  - S_LO: d_out = {16'h0000, word_reg[7:0]}.
  - page mirrors state with the same one-cycle register delay.
- Latency:
  - load -> d_out updated: 2 clk edges (capture, then output register).
  - key_n edge -> page change: 2 (sync) + DEBOUNCE_CYCLES + 2 cycles.
- Presses are accepted before the first load. Toggling then shows zeros and valid stays 0.
- Glitches on key_n shorter than DEBOUNCE_CYCLES produce no event.

Optional Feature:
- Macro: HEX_PAGE_SELECTOR_AUTO_SCROLL_EN.
- Defined:
  - Adds a free-running scroll counter 0..SCROLL_TICKS-1. At terminal count it issues a scroll tick that toggles the state, only when valid=1.
  - The counter clears on load and on any press event, so a manual action restarts the full interval.
  - The counter holds at 0 while valid=0.
- Undefined: no counter is built and the state changes only by key or load. SCROLL_TICKS is ignored.

Test Plan:
Test parameters: DEBOUNCE_CYCLES=4, SCROLL_TICKS=16.
1. Reset then load with data_in=32'hDEADBEEF -> two edges later d_out=24'hDEADBE, page=0, valid=1. Before the load: d_out=0, valid=0.
2. Hold key_n=0 for 10 cycles, then release -> exactly one toggle, d_out=24'h0000EF, page=1. Release does not toggle back. A second press gives d_out=24'hDEADBE.
3. key_n pulses low for 2 cycles only, repeated 5 times -> page stays 0 and d_out is unchanged.
4. In S_LO, assert load with 32'h12345678 in the same cycle a press event fires -> d_out=24'h123456, page=0. The press is dropped.
5. Assert rst_n=0 mid-debounce while in S_LO with word 32'h12345678 -> immediately d_out=0, page=0, valid=0. After release a 1-cycle stale key state produces no event.
6. With HEX_PAGE_SELECTOR_AUTO_SCROLL_EN defined, load 32'h12345678 -> page toggles every 16 cycles (d_out alternates 24'h123456 / 24'h000078). A press mid-interval restarts the 16-cycle count. With the macro undefined, page holds for 100 cycles.
